// File: rtl/alu_pipe_pkg.sv
// Shared opcode constants and FSM state type for the pipelined ALU.
// S[3:2] selects the operation class and S[1:0] selects the operation within that class.
package alu_pipe_pkg;

    localparam logic [1:0] CLS_ARITH = 2'b00;
    localparam logic [1:0] CLS_LOGIC = 2'b01;
    localparam logic [1:0] CLS_SHR   = 2'b10;
    localparam logic [1:0] CLS_SHL   = 2'b11;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_INC = 2'b10;
    localparam logic [1:0] OP_DEC = 2'b11;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational arithmetic and logic evaluation.
// Shift classes are handled by the caller; this block drives zeros for them.
module alu_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic [3:0]       s,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             v
);

    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

    logic [WIDTH:0] ext_a;
    logic [WIDTH:0] ext_b;
    logic [WIDTH:0] ext_c;
    logic [WIDTH:0] wide;

    assign ext_a = {1'b0, a};
    assign ext_b = {1'b0, b};
    assign ext_c = {{WIDTH{1'b0}}, c_in};

    // Bit WIDTH of the extended result is the carry on add and the borrow on subtract.
    always_comb begin
        wide   = '0;
        result = '0;
        c_out  = 1'b0;
        v      = 1'b0;
        if (s[3:2] == CLS_ARITH) begin
            case (s[1:0])
                OP_ADD: begin
                    wide = ext_a + ext_b + ext_c;
                    v    = (a[MSB] == b[MSB]) && (wide[MSB] != a[MSB]);
                end
                OP_SUB: begin
                    wide = ext_a - ext_b - ext_c;
                    v    = (a[MSB] != b[MSB]) && (wide[MSB] != a[MSB]);
                end
                OP_INC: begin
                    wide = ext_a + ONE;
                    v    = !a[MSB] && wide[MSB];
                end
                default: begin
                    wide = ext_a - ONE;
                    v    = a[MSB] && !wide[MSB];
                end
            endcase
            result = wide[WIDTH-1:0];
            c_out  = wide[WIDTH];
        end else if (s[3:2] == CLS_LOGIC) begin
            case (s[1:0])
                OP_AND:  result = a & b;
                OP_OR:   result = a | b;
                OP_XOR:  result = a ^ b;
                default: result = ~a;
            endcase
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: arithmetic and logic operations finish in one cycle, and shifts move one bit per cycle.
// The result is held in DONE until the consumer takes it.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         A,
    input  logic [WIDTH-1:0]         B,
    input  logic                     C_in,
    input  logic [3:0]               S,
    input  logic [$clog2(WIDTH)-1:0] SHAMT,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         D,
    output logic                     C_out,
    output logic                     z,
    output logic                     V,
    output logic                     N
);

    localparam int SW = $clog2(WIDTH);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] d_reg;
    logic             c_reg;
    logic             v_reg;
    logic [WIDTH-1:0] sh_data;
    logic [SW-1:0]    sh_cnt;
    logic             sh_left;
    logic [WIDTH-1:0] sh_next;
    logic             sh_out;
    logic [WIDTH-1:0] core_result;
    logic             core_c;
    logic             core_v;
    logic             accept;
    logic             is_shift;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a      (A),
        .b      (B),
        .c_in   (C_in),
        .s      (S),
        .result (core_result),
        .c_out  (core_c),
        .v      (core_v)
    );

    assign accept   = in_valid && (state == IDLE);
    assign is_shift = (S[3:2] == CLS_SHR) || (S[3:2] == CLS_SHL);
    assign sh_next  = sh_left ? {sh_data[WIDTH-2:0], 1'b0} : {1'b0, sh_data[WIDTH-1:1]};
    assign sh_out   = sh_left ? sh_data[WIDTH-1] : sh_data[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (accept) next_state = (is_shift && SHAMT != '0) ? SHIFT : DONE;
            SHIFT: if (sh_cnt == SW'(1)) next_state = DONE;
            DONE:  if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Non-shift results register at acceptance; D only updates when a shift completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_reg   <= '0;
            c_reg   <= 1'b0;
            v_reg   <= 1'b0;
            sh_data <= '0;
            sh_cnt  <= '0;
            sh_left <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!is_shift) begin
                            d_reg <= core_result;
                            c_reg <= core_c;
                            v_reg <= core_v;
                        end else if (SHAMT == '0) begin
                            d_reg <= A;
                            c_reg <= 1'b0;
                            v_reg <= 1'b0;
                        end else begin
                            sh_data <= A;
                            sh_cnt  <= SHAMT;
                            sh_left <= (S[3:2] == CLS_SHL);
                        end
                    end
                end
                SHIFT: begin
                    sh_data <= sh_next;
                    sh_cnt  <= sh_cnt - SW'(1);
                    if (sh_cnt == SW'(1)) begin
                        d_reg <= sh_next;
                        c_reg <= sh_out;
                        v_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign D         = d_reg;
    assign C_out     = c_reg;
    assign V         = v_reg;
    assign z         = (d_reg == '0);
    assign N         = d_reg[WIDTH-1];

endmodule
